// File: rtl/data_memory.sv
// rtl/data_memory.sv - byte-wide word-addressed data memory, combinational read, clocked write
module data_memory #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         ReadMem,
  input  logic         WriteMem,
  input  logic [W-1:0] DataIn,
  input  logic [A-1:0] DataAddress,
  output logic [W-1:0] DataOut
);

  localparam int DEPTH = 2 ** A;

  // Storage; benches reach core[i] hierarchically, so name and shape are fixed.
  logic [W-1:0] core [0:DEPTH-1];

  // Reset clears every word at once (no clock needed); otherwise write on the rising edge.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        core[i] <= '0;
      end
    end else if (WriteMem) begin
      core[DataAddress] <= DataIn;
    end
  end

  // Read path is purely combinational and forced to zero when not enabled; no write bypass.
  always_comb begin
    DataOut = '0;
    if (ReadMem) begin
      DataOut = core[DataAddress];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed self-checking bench for data_memory
module tb_data_memory;

  logic       CLK;
  logic       reset;
  logic       ReadMem;
  logic       WriteMem;
  logic [7:0] DataIn;
  logic [7:0] DataAddress;
  logic [7:0] DataOut;

  int vectors;
  int miscompares;

  data_memory #(.W(8), .A(8)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .ReadMem     (ReadMem),
    .WriteMem    (WriteMem),
    .DataIn      (DataIn),
    .DataAddress (DataAddress),
    .DataOut     (DataOut)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive a single port write in the low phase, let one rising edge perform it.
  task automatic port_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge CLK);
    DataAddress = addr;
    DataIn      = data;
    WriteMem    = 1'b1;
    @(posedge CLK);
    #1;
    WriteMem    = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    ReadMem     = 1'b1;
    WriteMem    = 1'b0;
    DataIn      = 8'h00;
    DataAddress = 8'h00;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("reset_dataout_addr0", {8'h00, DataOut}, 16'h0000);
    @(negedge CLK);
    reset = 1'b0;

    // Reset clear of hierarchical preloads, asynchronously between edges
    @(negedge CLK);
    dut.core[0]   = 8'hAA;
    dut.core[255] = 8'h55;
    DataAddress   = 8'h00;
    #1;
    check("preload_read_addr0", {8'h00, DataOut}, 16'h00AA);
    DataAddress = 8'hFF;
    #1;
    check("preload_read_addr255", {8'h00, DataOut}, 16'h0055);
    reset = 1'b1;
    #1;
    check("async_clear_core0", {8'h00, dut.core[0]}, 16'h0000);
    check("async_clear_core255", {8'h00, dut.core[255]}, 16'h0000);
    check("async_clear_out255", {8'h00, DataOut}, 16'h0000);
    DataAddress = 8'h00;
    #1;
    check("async_clear_out0", {8'h00, DataOut}, 16'h0000);
    reset = 1'b0;

    // Basic write then read, and read gating
    port_write(8'h10, 8'h3C);
    ReadMem = 1'b1;
    #1;
    check("basic_read_3c", {8'h00, DataOut}, 16'h003C);
    ReadMem = 1'b0;
    #1;
    check("readmem0_gates_out", {8'h00, DataOut}, 16'h0000);
    ReadMem = 1'b1;

    // Write disabled over several edges
    @(negedge CLK);
    DataAddress = 8'h10;
    DataIn      = 8'hFF;
    WriteMem    = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("write_disabled_core", {8'h00, dut.core[8'h10]}, 16'h003C);
    check("write_disabled_out", {8'h00, DataOut}, 16'h003C);

    // Same-cycle read and write: old value before edge, new value after
    port_write(8'h05, 8'h11);
    @(negedge CLK);
    DataAddress = 8'h05;
    DataIn      = 8'h22;
    WriteMem    = 1'b1;
    #1;
    check("rw_same_cycle_before", {8'h00, DataOut}, 16'h0011);
    @(posedge CLK);
    #1;
    check("rw_same_cycle_after", {8'h00, DataOut}, 16'h0022);
    WriteMem = 1'b0;

    // Hierarchical access, big-endian half-float operand and 16-bit result
    @(negedge CLK);
    dut.core[4] = 8'h3C;
    dut.core[5] = 8'h00;
    port_write(8'h06, 8'h00);
    port_write(8'h07, 8'h01);
    check("bigendian_result", {dut.core[6], dut.core[7]}, 16'h0001);
    DataAddress = 8'h04;
    #1;
    check("preload_read_addr4", {8'h00, DataOut}, 16'h003C);
    DataAddress = 8'h05;
    #1;
    check("preload_read_addr5", {8'h00, DataOut}, 16'h0000);

    // Address extremes write normally
    port_write(8'hFF, 8'hA5);
    port_write(8'h00, 8'h5A);
    check("write_addr255", {8'h00, dut.core[255]}, 16'h00A5);
    check("write_addr0", {8'h00, dut.core[0]}, 16'h005A);
    check("addr255_untouched_by_addr0", {8'h00, dut.core[255]}, 16'h00A5);

    // Write attempted while reset is held is ignored
    @(negedge CLK);
    reset       = 1'b1;
    DataAddress = 8'h03;
    DataIn      = 8'h77;
    WriteMem    = 1'b1;
    @(posedge CLK);
    #1;
    check("reset_held_out", {8'h00, DataOut}, 16'h0000);
    @(negedge CLK);
    WriteMem = 1'b0;
    reset    = 1'b0;
    #1;
    check("write_during_reset_core3", {8'h00, dut.core[3]}, 16'h0000);
    check("reset_cleared_addr10", {8'h00, dut.core[8'h10]}, 16'h0000);

    // First edge after reset release writes normally
    port_write(8'h03, 8'h77);
    DataAddress = 8'h03;
    #1;
    check("post_reset_write", {8'h00, DataOut}, 16'h0077);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
